// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          DEPTH_DEF    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. Push while full is accepted only with a same-cycle pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; readers only look at it while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches, buffers in-order
// responses, and drops responses that were in flight across a redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale_cnt;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] pcq_count;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop_head;
    logic          buf_full;
    logic          buf_empty;
    logic          pcq_full;
    logic          pcq_empty;
    logic [31:0]   rsp_pc;
    fetch_entry_t  head;
    fetch_entry_t  hold;
    fetch_entry_t  push_entry;
    logic          unused_status;

    // Counting outstanding requests (stale ones included) against free slots
    // guarantees every kept response finds room in the buffer.
    assign imem_req_valid = !rst && !redirect
                            && (({1'b0, outstanding} + {1'b0, occupancy}) < LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect && (stale_cnt == '0);
    assign pop_head       = !buf_empty && inst_ready && !redirect;
    assign push_entry     = '{pc: rsp_pc, inst: imem_rsp_data};

    assign inst_valid     = !buf_empty;
    assign inst_data      = buf_empty ? hold.inst : head.inst;
    assign inst_pc        = buf_empty ? hold.pc   : head.pc;
    assign unused_status  = ^{buf_full, pcq_full, pcq_empty, pcq_count, redirect_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
            outstanding <= '0;
            stale_cnt   <= '0;
            hold        <= '0;
        end else begin
            if (redirect)      fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            // Everything still in flight after this cycle's response belongs
            // to the old stream; no request is accepted during a redirect.
            if (redirect)
                stale_cnt <= outstanding - CW'(imem_rsp_valid);
            else if (imem_rsp_valid && (stale_cnt != '0))
                stale_cnt <= stale_cnt - 1'b1;

            if (!buf_empty) hold <= head;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop_head),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occupancy)
    );

    // PCs of live requests, matched to responses in order.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (redirect),
        .din   (fetch_pc),
        .dout  (rsp_pc),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count)
    );

    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));
    a_push_room: assert property (@(posedge clk) disable iff (rst)
        rsp_keep |-> (!buf_full || pop_head));
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 4, instruction buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  in-order response; at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 redirect  input  1  branch/jump taken, from the Datapath.
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] ignored and forced to 0.
REQ-012 inst_valid  output  1  buffered instruction available to the Datapath.
REQ-013 inst_ready  input  1  Datapath consumes the head entry this cycle.
REQ-014 inst_data  output  32  head instruction word.
REQ-015 inst_pc  output  32  address of head instruction.

Function
REQ-016 Request accepted when imem_req_valid and imem_req_ready are both high; fetch PC then advances by 4, wrapping 32'hFFFF_FFFC to 0.
REQ-017 imem_req_valid high only when outstanding + occupancy < DEPTH and redirect is low; a valid response therefore never finds the buffer full.
REQ-018 Outstanding count: +1 per accepted request, -1 per imem_rsp_valid; +1 and -1 together leave it unchanged; 0..DEPTH range.
REQ-019 Each non-stale response pushes {PC of matching request, imem_rsp_data} into the buffer; request PCs kept in a DEPTH-entry in-flight PC queue.
REQ-020 Head entry pops when inst_valid and inst_ready; push and pop together keep occupancy unchanged, including at full and at empty.
REQ-021 Empty buffer: inst_valid low, inst_data/inst_pc hold last values; no combinational response-to-output bypass, so minimum latency accept-to-inst_valid is response cycle + 1.
REQ-022 redirect: same edge flushes buffer and in-flight PC queue, fetch PC <= redirect_pc; stale count <= outstanding after this cycle's response is removed.
REQ-023 While stale count > 0, each imem_rsp_valid decrements it and is discarded, never pushed.
REQ-024 redirect together with inst_ready: pop is ignored, flush wins; redirect with a response: that response is discarded.
REQ-025 Back-to-back redirects: last one wins; stale count accumulates correctly.
REQ-026 Throughput: one instruction per cycle sustained when memory is always ready and latency is 1.

Reset
REQ-027 On rst assertion, asynchronously: fetch PC = RESET_PC, occupancy = 0, outstanding = 0, stale = 0, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, imem_req_addr = RESET_PC.
REQ-028 First request issued on the first rising edge after rst deasserts; responses arriving during reset are ignored.
REQ-029 Reset mid-operation discards all buffered and in-flight work; no stale accounting carries over.

Structure
REQ-030 Shared package fetch_pkg holds RESET_PC default, DEPTH default, and the packed entry typedef {pc[31:0], inst[31:0]}.
REQ-031 Buffer is one sub-module fetch_fifo: parameterised synchronous FIFO with push, pop, flush, full, empty, count.

Verification
REQ-032 Reset release, 1-cycle memory, inst_ready=1 -> inst_pc 0,4,8,12 on consecutive cycles after 2-cycle fill.
REQ-033 inst_ready=0 for 10 cycles -> exactly 4 entries held, imem_req_valid low, none lost; release -> PCs 0..12 drain in order.
REQ-034 3-cycle latency, 2 requests outstanding, redirect to 0x100 -> both old responses discarded, next inst_pc = 0x100.
REQ-035 redirect with inst_ready and imem_rsp_valid in the same cycle -> buffer empty next cycle, stale count = outstanding - 1.
REQ-036 rst asserted mid-stream between edges -> outputs zero immediately, fetch restarts at RESET_PC.
